// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display path.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 are blank.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd_i,
  output logic [6:0]         seg_o
);

  // Decode one BCD digit to its segment pattern.
  always_comb begin
    seg_o = SEG_BLANK;
    unique case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment scan driver with frame-synchronous
// double-buffered loading, per-digit blink, decimal points and
// leading-zero blanking. All display outputs are registered.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BLINK_DIV  = 100
) (
  input  logic                          clk200Hz,
  input  logic                          rst,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  input  logic                          lz_blank_en,
  input  logic                          load,
  output logic                          load_ack,
  output logic                          frame_start,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [6:0]                    segments,
  output logic                          dp
);

  localparam int unsigned SCAN_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BLINK_W = $clog2(BLINK_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [SCAN_W-1:0]               scan_q, scan_d;
  logic [BLINK_W-1:0]              blink_cnt_q, blink_cnt_d;
  logic                            blink_phase_q, blink_phase_d;
  logic [DIGIT_W*NUM_DIGITS-1:0]   stg_digits_q, stg_digits_d;
  logic [NUM_DIGITS-1:0]           stg_dp_q, stg_dp_d;
  logic [NUM_DIGITS-1:0]           stg_mask_q, stg_mask_d;
  logic                            pending_q, pending_d;
  logic [DIGIT_W*NUM_DIGITS-1:0]   disp_digits_q, disp_digits_d;
  logic [NUM_DIGITS-1:0]           disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]           disp_mask_q, disp_mask_d;

  logic [NUM_DIGITS-1:0]           anode_q, anode_d;
  logic [6:0]                      seg_q, seg_d;
  logic                            dp_q, dp_d;
  logic                            frame_q, frame_d;
  logic                            ack_q, ack_d;

  logic                            wrap;
  logic [DIGIT_W-1:0]              cur_digit;
  logic                            cur_dp;
  logic                            cur_mask;
  logic                            cur_lz;
  logic [NUM_DIGITS-1:0]           lz_zero;
  logic                            zero_above;
  logic                            blink_blank;
  logic [6:0]                      seg_raw;

  // Scan counter, blink timebase and the staging/display handshake.
  // The commit reads the pre-edge staging value, so a load coinciding
  // with a wrap lands in staging and waits for the following wrap.
  always_comb begin
    wrap          = (scan_q == SCAN_LAST);
    scan_d        = wrap ? '0 : scan_q + 1'b1;
    blink_cnt_d   = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = (blink_cnt_q == BLINK_LAST) ? ~blink_phase_q : blink_phase_q;

    stg_digits_d  = stg_digits_q;
    stg_dp_d      = stg_dp_q;
    stg_mask_d    = stg_mask_q;
    pending_d     = pending_q;
    disp_digits_d = disp_digits_q;
    disp_dp_d     = disp_dp_q;
    disp_mask_d   = disp_mask_q;
    ack_d         = 1'b0;

    if (wrap && pending_q) begin
      disp_digits_d = stg_digits_q;
      disp_dp_d     = stg_dp_q;
      disp_mask_d   = stg_mask_q;
      pending_d     = 1'b0;
      ack_d         = 1'b1;
    end

    if (load) begin
      stg_digits_d = digits_in;
      stg_dp_d     = dp_in;
      stg_mask_d   = blink_mask;
      pending_d    = 1'b1;
    end
  end

  // Leading-zero prefix: a digit is blankable when it and every digit
  // above it are zero; digit 0 is never included.
  always_comb begin
    lz_zero    = '0;
    zero_above = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
      if (disp_digits_q[(NUM_DIGITS-1-k)*DIGIT_W +: DIGIT_W] != '0) begin
        zero_above = 1'b0;
      end
      lz_zero[NUM_DIGITS-1-k] = zero_above;
    end
  end

  // Select the attributes of the digit currently being scanned.
  always_comb begin
    cur_digit = '0;
    cur_dp    = 1'b0;
    cur_mask  = 1'b0;
    cur_lz    = 1'b0;
    anode_d   = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (scan_q == SCAN_W'(i)) begin
        cur_digit  = disp_digits_q[i*DIGIT_W +: DIGIT_W];
        cur_dp     = disp_dp_q[i];
        cur_mask   = disp_mask_q[i];
        cur_lz     = lz_zero[i];
        anode_d[i] = 1'b0;
      end
    end
  end

  bcd_to_seg u_dec (
    .bcd_i (cur_digit),
    .seg_o (seg_raw)
  );

  // Compose the next output pattern; blink blanks dp too, zero-blanking does not.
  always_comb begin
    blink_blank = blink_phase_q & cur_mask;
    seg_d       = (blink_blank || (lz_blank_en && cur_lz)) ? SEG_BLANK : seg_raw;
    dp_d        = ~(cur_dp & ~blink_blank);
    frame_d     = (scan_q == '0);
  end

  // State registers.
  always_ff @(posedge clk200Hz or posedge rst) begin
    if (rst) begin
      scan_q        <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      stg_digits_q  <= '0;
      stg_dp_q      <= '0;
      stg_mask_q    <= '0;
      pending_q     <= 1'b0;
      disp_digits_q <= '0;
      disp_dp_q     <= '0;
      disp_mask_q   <= '0;
    end else begin
      scan_q        <= scan_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      stg_digits_q  <= stg_digits_d;
      stg_dp_q      <= stg_dp_d;
      stg_mask_q    <= stg_mask_d;
      pending_q     <= pending_d;
      disp_digits_q <= disp_digits_d;
      disp_dp_q     <= disp_dp_d;
      disp_mask_q   <= disp_mask_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk200Hz or posedge rst) begin
    if (rst) begin
      anode_q <= '1;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
      ack_q   <= ack_d;
    end
  end

  assign anode       = anode_q;
  assign segments    = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_q;
  assign load_ack    = ack_q;

endmodule
